// File: rtl/red_pitaya_refclk_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_refclk_supervisor
//  Brief    : Measures and qualifies up to NCH external reference clocks by
//             edge counting over a fixed gate, then selects the best
//             reference for the ADC-clock MMCM. It sequences the MMCM reset,
//             waits for lock with a timeout, and recovers from faults.
//  Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_refclk_supervisor #(
    parameter int NCH          = 2,
    parameter int CW           = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int GATE_CYCLES  = 125000,
    parameter int EXP_MIN      = 9990,
    parameter int EXP_MAX      = 10010,
    parameter int GOOD_GATES   = 4,
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_TIMEOUT = 125000,
    parameter int REVERTIVE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [NCH-1:0]             ref_i,
    input  logic                       pll_locked_i,
    output logic [NCH*CW-1:0]          freq_o,
    output logic                       freq_vld_o,
    output logic [NCH-1:0]             ref_ok_o,
    output logic [$clog2(NCH+1)-1:0]   sel_o,
    output logic                       pll_rst_o,
    output logic                       locked_o,
    output logic [2:0]                 state_o,
    output logic [7:0]                 fault_cnt_o
);

    localparam int c_sel_w  = $clog2(NCH + 1);
    localparam int c_gate_w = $clog2(GATE_CYCLES);
    localparam int c_run_w  = $clog2(GOOD_GATES + 1);
    localparam int c_rst_w  = $clog2(RST_CYCLES + 1);
    localparam int c_to_w   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_reset     = 3'd1;
    localparam logic [2:0] c_st_wait_lock = 3'd2;
    localparam logic [2:0] c_st_locked    = 3'd3;
    localparam logic [2:0] c_st_fault     = 3'd4;

    localparam logic [c_sel_w-1:0] c_sel_internal = c_sel_w'(NCH);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [NCH-1:0]          r_ref_sync [SYNC_STAGES];
    logic [NCH-1:0]          r_ref_prev;
    logic [SYNC_STAGES-1:0]  r_lock_sync;
    logic [c_gate_w-1:0]     r_gate_cnt;
    logic [CW-1:0]           r_edge_cnt [NCH];
    logic [CW-1:0]           r_freq     [NCH];
    logic [c_run_w-1:0]      r_run      [NCH];
    logic [NCH-1:0]          r_ref_ok;
    logic                    r_freq_vld;

    logic [2:0]              r_state;
    logic [c_sel_w-1:0]      r_sel;
    logic                    r_pll_rst;
    logic                    r_locked;
    logic [7:0]              r_fault_cnt;
    logic [c_rst_w-1:0]      r_rst_cnt;
    logic [c_to_w-1:0]       r_to_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [NCH-1:0]          w_edge;
    logic                    w_lock;
    logic                    w_gate_end;
    logic [CW-1:0]           w_cnt_final [NCH];
    logic [NCH-1:0]          w_in_range;
    logic [c_run_w-1:0]      w_run_inc  [NCH];
    logic [c_sel_w-1:0]      w_cand;
    logic                    w_sel_bad;
    logic                    w_revert;
    logic [7:0]              w_fault_inc;

    assign w_edge      = r_ref_sync[SYNC_STAGES-1] & ~r_ref_prev;
    assign w_lock      = r_lock_sync[SYNC_STAGES-1];
    assign w_gate_end  = (r_gate_cnt == c_gate_w'(GATE_CYCLES - 1));
    assign w_fault_inc = (r_fault_cnt == 8'hFF) ? r_fault_cnt : r_fault_cnt + 8'd1;
    assign w_revert    = (REVERTIVE != 0) && (w_cand < r_sel);

    // Per-channel final count (including an edge on the gate-end cycle) and qualification
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_cnt_final[k] = r_edge_cnt[k];
            if (w_edge[k] && (r_edge_cnt[k] != {CW{1'b1}})) begin
                w_cnt_final[k] = r_edge_cnt[k] + 1'b1;
            end
            w_in_range[k] = (w_cnt_final[k] >= CW'(EXP_MIN)) && (w_cnt_final[k] <= CW'(EXP_MAX));
            w_run_inc[k]  = (r_run[k] >= c_run_w'(GOOD_GATES)) ? r_run[k] : r_run[k] + 1'b1;
        end
    end

    // Lowest-index good reference wins; internal source when none is good
    always_comb begin
        w_cand = c_sel_internal;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (r_ref_ok[k]) begin
                w_cand = c_sel_w'(k);
            end
        end
    end

    // Selected external reference has lost its qualification
    always_comb begin
        w_sel_bad = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if ((r_sel == c_sel_w'(k)) && !r_ref_ok[k]) begin
                w_sel_bad = 1'b1;
            end
        end
    end

    // Synchronize the asynchronous reference and lock inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_ref_sync[s] <= '0;
            end
            r_ref_prev  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_ref_sync[0] <= ref_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_ref_sync[s] <= r_ref_sync[s-1];
            end
            r_ref_prev  <= r_ref_sync[SYNC_STAGES-1];
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    // Gate timer, edge counters, frequency results and good-run qualification
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_freq_vld <= 1'b0;
            r_ref_ok   <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_edge_cnt[k] <= '0;
                r_freq[k]     <= '0;
                r_run[k]      <= '0;
            end
        end else begin
            r_freq_vld <= w_gate_end;
            r_gate_cnt <= w_gate_end ? '0 : r_gate_cnt + 1'b1;
            for (int k = 0; k < NCH; k++) begin
                if (w_gate_end) begin
                    r_freq[k]     <= w_cnt_final[k];
                    r_edge_cnt[k] <= '0;
                    if (w_in_range[k]) begin
                        r_run[k]    <= w_run_inc[k];
                        r_ref_ok[k] <= (w_run_inc[k] >= c_run_w'(GOOD_GATES));
                    end else begin
                        r_run[k]    <= '0;
                        r_ref_ok[k] <= 1'b0;
                    end
                end else begin
                    r_edge_cnt[k] <= w_cnt_final[k];
                end
            end
        end
    end

    // Control FSM: reference selection, MMCM reset sequencing and lock supervision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_sel       <= c_sel_internal;
            r_pll_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_fault_cnt <= '0;
            r_rst_cnt   <= '0;
            r_to_cnt    <= '0;
        end else if (!en_i) begin
            r_state   <= c_st_idle;
            r_sel     <= c_sel_internal;
            r_pll_rst <= 1'b1;
            r_locked  <= 1'b0;
            r_rst_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_pll_rst <= 1'b1;
                    r_locked  <= 1'b0;
                    r_sel     <= w_cand;
                    r_rst_cnt <= '0;
                    r_state   <= c_st_reset;
                end
                c_st_reset: begin
                    if (r_rst_cnt == c_rst_w'(RST_CYCLES - 1)) begin
                        r_pll_rst <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= c_st_wait_lock;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                c_st_wait_lock: begin
                    if (w_lock) begin
                        r_locked <= 1'b1;
                        r_state  <= c_st_locked;
                    end else if (r_to_cnt == c_to_w'(LOCK_TIMEOUT - 1)) begin
                        r_pll_rst   <= 1'b1;
                        r_fault_cnt <= w_fault_inc;
                        r_state     <= c_st_fault;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_st_locked: begin
                    // Lock loss and a reference change together make one restart
                    if (!w_lock || w_sel_bad || w_revert) begin
                        r_sel     <= (w_sel_bad || w_revert) ? w_cand : r_sel;
                        r_pll_rst <= 1'b1;
                        r_locked  <= 1'b0;
                        r_rst_cnt <= '0;
                        r_state   <= c_st_reset;
                        if (!w_lock) begin
                            r_fault_cnt <= w_fault_inc;
                        end
                    end
                end
                c_st_fault: begin
                    r_pll_rst <= 1'b1;
                    if (w_gate_end) begin
                        r_sel     <= w_cand;
                        r_rst_cnt <= '0;
                        r_state   <= c_st_reset;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_pll_rst <= 1'b1;
                    r_locked  <= 1'b0;
                end
            endcase
        end
    end

    // Output packing
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_freq_out
            assign freq_o[k*CW +: CW] = r_freq[k];
        end
    endgenerate

    assign freq_vld_o  = r_freq_vld;
    assign ref_ok_o    = r_ref_ok;
    assign sel_o       = r_sel;
    assign pll_rst_o   = r_pll_rst;
    assign locked_o    = r_locked;
    assign state_o     = r_state;
    assign fault_cnt_o = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_refclk_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_red_pitaya_refclk_supervisor
//  Brief    : Directed bench for the reference-clock supervisor: a revertive
//             instance plus a non-revertive instance, 10 MHz references
//             sampled by a 125 MHz clock, and a simple MMCM lock model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_refclk_supervisor;

    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a;
    logic        en_b;
    logic        ref_tog = 1'b0;
    logic [1:0]  ref_run;
    logic [1:0]  ref_i;
    logic        lock_en;

    logic [31:0] freq_a, freq_b;
    logic        vld_a, vld_b;
    logic [1:0]  ok_a, ok_b;
    logic [1:0]  sel_a, sel_b;
    logic        prst_a, prst_b;
    logic        locked_a, locked_b;
    logic [2:0]  state_a, state_b;
    logic [7:0]  fault_a, fault_b;
    logic        mmcm_lock_a, mmcm_lock_b;
    int          lk_cnt_a = 0;
    int          lk_cnt_b = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #4 clk = ~clk;

    initial begin
        #3;
        forever #50 ref_tog = ~ref_tog;
    end

    assign ref_i = {ref_tog & ref_run[1], ref_tog & ref_run[0]};

    // MMCM model: locks 50 cycles after its reset is released
    always @(posedge clk) begin
        if (prst_a) lk_cnt_a <= 0;
        else if (lk_cnt_a < 50) lk_cnt_a <= lk_cnt_a + 1;
        if (prst_b) lk_cnt_b <= 0;
        else if (lk_cnt_b < 50) lk_cnt_b <= lk_cnt_b + 1;
    end
    assign mmcm_lock_a = lock_en && !prst_a && (lk_cnt_a == 50);
    assign mmcm_lock_b = lock_en && !prst_b && (lk_cnt_b == 50);

    red_pitaya_refclk_supervisor #(
        .NCH(2), .CW(CW), .SYNC_STAGES(2), .GATE_CYCLES(1000), .EXP_MIN(78), .EXP_MAX(82),
        .GOOD_GATES(4), .RST_CYCLES(8), .LOCK_TIMEOUT(200), .REVERTIVE(1)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_a), .ref_i(ref_i), .pll_locked_i(mmcm_lock_a),
        .freq_o(freq_a), .freq_vld_o(vld_a), .ref_ok_o(ok_a), .sel_o(sel_a),
        .pll_rst_o(prst_a), .locked_o(locked_a), .state_o(state_a), .fault_cnt_o(fault_a)
    );

    red_pitaya_refclk_supervisor #(
        .NCH(2), .CW(CW), .SYNC_STAGES(2), .GATE_CYCLES(1000), .EXP_MIN(78), .EXP_MAX(82),
        .GOOD_GATES(4), .RST_CYCLES(8), .LOCK_TIMEOUT(200), .REVERTIVE(0)
    ) dut_nr (
        .clk(clk), .rst(rst), .en_i(en_b), .ref_i(ref_i), .pll_locked_i(mmcm_lock_b),
        .freq_o(freq_b), .freq_vld_o(vld_b), .ref_ok_o(ok_b), .sel_o(sel_b),
        .pll_rst_o(prst_b), .locked_o(locked_b), .state_o(state_b), .fault_cnt_o(fault_b)
    );

    task automatic wait_state(input bit which, input logic [2:0] s, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if ((which ? state_b : state_a) == s) ok = 1'b1;
        end
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (vld_a) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ref_run = 2'b11; lock_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (freq_a !== 32'd0)  begin n_fail++; $display("FAIL reset_freq got=%0h exp=0", freq_a); end
        n_tests++; if (vld_a !== 1'b0)    begin n_fail++; $display("FAIL reset_vld got=%0b exp=0", vld_a); end
        n_tests++; if (ok_a !== 2'b00)    begin n_fail++; $display("FAIL reset_ok got=%0b exp=00", ok_a); end
        n_tests++; if (sel_a !== 2'd2)    begin n_fail++; $display("FAIL reset_sel got=%0d exp=2", sel_a); end
        n_tests++; if (prst_a !== 1'b1)   begin n_fail++; $display("FAIL reset_pllrst got=%0b exp=1", prst_a); end
        n_tests++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%0b exp=0", locked_a); end
        n_tests++; if (state_a !== 3'd0)  begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_a); end
        n_tests++; if (fault_a !== 8'd0)  begin n_fail++; $display("FAIL reset_fault got=%0d exp=0", fault_a); end
    endtask

    task automatic test_qualify;
        bit ok;
        en_a = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            wait_vld(1100, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL qual_vld_timeout gate=%0d got=0 exp=1", g); end
            n_tests++;
            if (ok_a !== ((g < 4) ? 2'b00 : 2'b11)) begin
                n_fail++; $display("FAIL qual_ref_ok gate=%0d got=%0b exp=%0b", g, ok_a, (g < 4) ? 2'b00 : 2'b11);
            end
            if (g == 3) begin
                n_tests++; if (state_a !== 3'd3 || sel_a !== 2'd2) begin
                    n_fail++; $display("FAIL internal_lock got state=%0d sel=%0d exp state=3 sel=2", state_a, sel_a);
                end
            end
        end
        n_tests++; if (freq_a[0 +: CW] !== 16'd80) begin n_fail++; $display("FAIL qual_freq0 got=%0d exp=80", freq_a[0 +: CW]); end
        n_tests++; if (freq_a[CW +: CW] !== 16'd80) begin n_fail++; $display("FAIL qual_freq1 got=%0d exp=80", freq_a[CW +: CW]); end
        @(negedge clk);
        n_tests++; if (state_a !== 3'd1 || sel_a !== 2'd0 || prst_a !== 1'b1) begin
            n_fail++; $display("FAIL revert_to_ref0 got state=%0d sel=%0d rst=%0b exp state=1 sel=0 rst=1", state_a, sel_a, prst_a);
        end
        wait_state(1'b0, 3'd3, 300, ok);
        n_tests++; if (!ok || sel_a !== 2'd0 || locked_a !== 1'b1 || fault_a !== 8'd0) begin
            n_fail++; $display("FAIL lock_ref0 got ok=%0b sel=%0d locked=%0b fault=%0d exp 1/0/1/0", ok, sel_a, locked_a, fault_a);
        end
        en_b = 1'b1;
        wait_state(1'b1, 3'd3, 300, ok);
        n_tests++; if (!ok || sel_b !== 2'd0) begin
            n_fail++; $display("FAIL nr_lock_ref0 got ok=%0b sel=%0d exp ok=1 sel=0", ok, sel_b);
        end
    endtask

    task automatic test_ref_loss;
        bit ok;
        wait_vld(1100, ok);
        ref_run[0] = 1'b0;
        wait_vld(1100, ok);
        n_tests++; if (!ok || ok_a !== 2'b10 || freq_a[0 +: CW] >= 16'd78) begin
            n_fail++; $display("FAIL loss_disqualify got ok=%0b ref_ok=%0b freq0=%0d exp 1/10/<78", ok, ok_a, freq_a[0 +: CW]);
        end
        @(negedge clk);
        n_tests++; if (state_a !== 3'd1 || sel_a !== 2'd1) begin
            n_fail++; $display("FAIL loss_switch got state=%0d sel=%0d exp state=1 sel=1", state_a, sel_a);
        end
        wait_state(1'b0, 3'd3, 300, ok);
        n_tests++; if (!ok || sel_a !== 2'd1 || fault_a !== 8'd0) begin
            n_fail++; $display("FAIL loss_relock got ok=%0b sel=%0d fault=%0d exp 1/1/0", ok, sel_a, fault_a);
        end
        wait_state(1'b1, 3'd3, 300, ok);
        n_tests++; if (!ok || sel_b !== 2'd1) begin
            n_fail++; $display("FAIL nr_loss_switch got ok=%0b sel=%0d exp ok=1 sel=1", ok, sel_b);
        end
        wait_vld(1100, ok);
        n_tests++; if (!ok || freq_a[0 +: CW] !== 16'd0 || freq_a[CW +: CW] !== 16'd80) begin
            n_fail++; $display("FAIL loss_freq got f0=%0d f1=%0d exp f0=0 f1=80", freq_a[0 +: CW], freq_a[CW +: CW]);
        end
    endtask

    task automatic test_revert;
        bit ok;
        bit good;
        wait_vld(1100, ok);
        ref_run[0] = 1'b1;
        good = 1'b0;
        for (int g = 0; g < 6 && !good; g++) begin
            wait_vld(1100, ok);
            if (ok_a == 2'b11) good = 1'b1;
        end
        n_tests++; if (!good) begin n_fail++; $display("FAIL revert_requalify got ref_ok=%0b exp=11", ok_a); end
        @(negedge clk);
        n_tests++; if (state_a !== 3'd1 || sel_a !== 2'd0) begin
            n_fail++; $display("FAIL revert_switch got state=%0d sel=%0d exp state=1 sel=0", state_a, sel_a);
        end
        wait_state(1'b0, 3'd3, 300, ok);
        n_tests++; if (!ok || sel_a !== 2'd0 || fault_a !== 8'd0) begin
            n_fail++; $display("FAIL revert_relock got ok=%0b sel=%0d fault=%0d exp 1/0/0", ok, sel_a, fault_a);
        end
        n_tests++; if (state_b !== 3'd3 || sel_b !== 2'd1) begin
            n_fail++; $display("FAIL nr_no_revert got state=%0d sel=%0d exp state=3 sel=1", state_b, sel_b);
        end
    endtask

    task automatic test_lock_drop;
        bit ok;
        lock_en = 1'b0;
        wait_state(1'b0, 3'd1, 10, ok);
        lock_en = 1'b1;
        n_tests++; if (!ok || fault_a !== 8'd1 || sel_a !== 2'd0) begin
            n_fail++; $display("FAIL drop_reset got ok=%0b fault=%0d sel=%0d exp 1/1/0", ok, fault_a, sel_a);
        end
        wait_state(1'b0, 3'd3, 300, ok);
        n_tests++; if (!ok || locked_a !== 1'b1) begin
            n_fail++; $display("FAIL drop_relock got ok=%0b locked=%0b exp 1/1", ok, locked_a);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        bit stayed;
        int cyc;
        lock_en = 1'b0;
        wait_state(1'b0, 3'd1, 10, ok);
        n_tests++; if (!ok || fault_a !== 8'd2) begin
            n_fail++; $display("FAIL tmo_drop got ok=%0b fault=%0d exp 1/2", ok, fault_a);
        end
        wait_state(1'b0, 3'd2, 20, ok);
        cyc = 1;
        while (state_a == 3'd2 && cyc < 1000) begin
            @(negedge clk);
            if (state_a == 3'd2) cyc++;
        end
        n_tests++; if (cyc != 200 || state_a !== 3'd4 || fault_a !== 8'd3 || prst_a !== 1'b1) begin
            n_fail++; $display("FAIL tmo_first got cyc=%0d state=%0d fault=%0d rst=%0b exp 200/4/3/1", cyc, state_a, fault_a, prst_a);
        end
        stayed = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 1100 && !ok; n++) begin
            @(negedge clk);
            if (vld_a) ok = 1'b1;
            else if (state_a !== 3'd4) stayed = 1'b0;
        end
        n_tests++; if (!ok || !stayed || state_a !== 3'd1) begin
            n_fail++; $display("FAIL fault_hold got vld=%0b held=%0b state=%0d exp 1/1/1", ok, stayed, state_a);
        end
        wait_state(1'b0, 3'd4, 400, ok);
        n_tests++; if (!ok || fault_a !== 8'd4) begin
            n_fail++; $display("FAIL tmo_second got ok=%0b fault=%0d exp 1/4", ok, fault_a);
        end
    endtask

    task automatic test_enable;
        bit ok;
        wait_state(1'b0, 3'd2, 1200, ok);
        repeat (5) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        n_tests++; if (!ok || state_a !== 3'd0 || prst_a !== 1'b1 || sel_a !== 2'd2 || locked_a !== 1'b0) begin
            n_fail++; $display("FAIL en_off got ok=%0b state=%0d rst=%0b sel=%0d locked=%0b exp 1/0/1/2/0", ok, state_a, prst_a, sel_a, locked_a);
        end
        wait_vld(1100, ok);
        n_tests++; if (!ok || ok_a !== 2'b11) begin
            n_fail++; $display("FAIL en_off_measure got vld=%0b ref_ok=%0b exp 1/11", ok, ok_a);
        end
        lock_en = 1'b1;
        en_a = 1'b1;
        wait_state(1'b0, 3'd3, 400, ok);
        n_tests++; if (!ok || sel_a !== 2'd0) begin
            n_fail++; $display("FAIL en_on_relock got ok=%0b sel=%0d exp 1/0", ok, sel_a);
        end
    endtask

    task automatic test_async_rst;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++; if (freq_a !== 32'd0 || vld_a !== 1'b0 || ok_a !== 2'b00 || sel_a !== 2'd2) begin
            n_fail++; $display("FAIL arst_meas got freq=%0h vld=%0b ok=%0b sel=%0d exp 0/0/00/2", freq_a, vld_a, ok_a, sel_a);
        end
        n_tests++; if (prst_a !== 1'b1 || locked_a !== 1'b0 || state_a !== 3'd0 || fault_a !== 8'd0) begin
            n_fail++; $display("FAIL arst_fsm got rst=%0b locked=%0b state=%0d fault=%0d exp 1/0/0/0", prst_a, locked_a, state_a, fault_a);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_qualify();
        test_ref_loss();
        test_revert();
        test_lock_drop();
        test_timeout();
        test_enable();
        test_async_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
